wb_master_bridge: RTL

- Responder end of the core-side `wb*` request interface that the core memory controller drives: accepts one single-word request at a time and runs it as a Wishbone B4 classic master cycle.
- Returns read data and a busy indication to the controller.
- Sits between the core memory controller and the SoC Wishbone interconnect.
- Adds a bus timeout so a missing slave can never hang the core.

---
 rtl/wb_master_bridge.sv | 131 +++++++++++++
 1 files changed

// File: rtl/wb_master_bridge.sv
// Single-word Wishbone B4 classic master fronting the core memory controller.
// state  | meaning
// S_IDLE | no cycle on the bus; a request with wbEnable=1 is latched here
// S_BUS  | cyc/stb held until ack, err or timeout
module wb_master_bridge #(
  parameter logic [3:0]  ADDRESS_PREFIX = 4'h3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] wbAddress,
  input  logic [3:0]  wbByteSelect,
  input  logic        wbEnable,
  input  logic        wbWriteEnable,
  input  logic [31:0] wbDataWrite,
  output logic [31:0] wbDataRead,
  output logic        wbBusy,
  output logic        wbError,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {S_IDLE, S_BUS} state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^wbAddress[1:0];
  assign timeout = TO_EN && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      rdat_q  <= 32'hFFFF_FFFF;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (wbEnable) begin
          state_d = S_BUS;
          cyc_d   = 1'b1;
          we_d    = wbWriteEnable;
          sel_d   = wbByteSelect;
          adr_d   = {ADDRESS_PREFIX, wbAddress[27:2], 2'b00};
          wdat_d  = wbWriteEnable ? wbDataWrite : 32'h0;
          cnt_d   = '0;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + CW'(1);
        // err outranks a simultaneous ack
        if (wb_err_i || timeout || wb_ack_i) begin
          if (wb_err_i || timeout) begin
            rdat_d = 32'hFFFF_FFFF;
            err_d  = 1'b1;
          end else if (!we_q) begin
            rdat_d = wb_data_i;
          end
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          adr_d   = 32'h0;
          wdat_d  = 32'h0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wbBusy     = (state_q == S_BUS);
  assign wbError    = err_q;
  assign wbDataRead = rdat_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_data_o  = wdat_q;

endmodule
